addressing_offset_loader: RTL

- Sequencer that produces the Programmed Offset (PO) and Default Offset (DO) update writes consumed by the operand addressing stage.
- Takes load commands plus a data-word stream and emits one `write_addr`/`write_data` pair per accepted word.
- Each write issues only in the target thread's barrel slot, so per-thread PO/DO memories are written by the correct thread.
- Sits between the configuration/IO side and the shared `write_addr`/`write_data` port of the addressing stage.

---
 rtl/addressing_offset_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/addressing_offset_loader.sv
// addressing_offset_loader: sequences PO/DO update writes into the
// operand addressing stage, one write per target-thread barrel slot.
module addressing_offset_loader #(
   parameter int WRITE_WORD_WIDTH   = 36,
   parameter int WRITE_ADDR_WIDTH   = 12,
   parameter logic [WRITE_ADDR_WIDTH-1:0] A_PO_ADDR_BASE  = '0,
   parameter logic [WRITE_ADDR_WIDTH-1:0] B_PO_ADDR_BASE  = '0,
   parameter logic [WRITE_ADDR_WIDTH-1:0] DA_PO_ADDR_BASE = '0,
   parameter logic [WRITE_ADDR_WIDTH-1:0] DB_PO_ADDR_BASE = '0,
   parameter logic [WRITE_ADDR_WIDTH-1:0] DO_ADDR         = '0,
   parameter int PO_ENTRY_COUNT     = 4,
   parameter int PO_ENTRY_WIDTH     = 2,
   parameter int THREAD_COUNT       = 8,
   parameter int THREAD_COUNT_WIDTH = 3
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [THREAD_COUNT_WIDTH-1:0] cmd_thread,
   input  logic [1:0]                    cmd_operand,
   input  logic                          cmd_do,
   input  logic [PO_ENTRY_WIDTH-1:0]     cmd_first,
   input  logic [PO_ENTRY_WIDTH:0]       cmd_count,
   input  logic                          data_valid,
   output logic                          data_ready,
   input  logic [WRITE_WORD_WIDTH-1:0]   data_in,
   input  logic [THREAD_COUNT_WIDTH-1:0] current_thread,
   input  logic                          slot_cancel,
   output logic                          write_valid,
   output logic [WRITE_ADDR_WIDTH-1:0]   write_addr,
   output logic [WRITE_WORD_WIDTH-1:0]   write_data,
   output logic                          busy,
   output logic                          done,
   output logic                          error
);

   localparam int AW = WRITE_ADDR_WIDTH;
   localparam int CW = PO_ENTRY_WIDTH + 2;
   localparam logic [PO_ENTRY_WIDTH:0] ONE = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   state_t                        r_state;
   state_t                        w_next;
   logic [THREAD_COUNT_WIDTH-1:0] r_thread;
   logic [AW-1:0]                 r_base;
   logic [PO_ENTRY_WIDTH:0]       r_count;
   logic [PO_ENTRY_WIDTH:0]       r_index;
   logic                          r_error;
   logic [AW-1:0]                 r_last_addr;
   logic [WRITE_WORD_WIDTH-1:0]   r_last_data;

   logic [AW-1:0]                 w_po_base;
   logic [AW-1:0]                 w_start;
   logic [CW-1:0]                 w_span;
   logic                          w_reject;
   logic                          w_accept;
   logic                          w_hit;
   logic                          w_slot;
   logic                          w_write;
   logic                          w_last;
   logic [AW-1:0]                 w_addr;

   // Operand PO base selection and command legality check
   always_comb begin
      w_po_base = A_PO_ADDR_BASE;
      unique case (cmd_operand)
         2'd0:    w_po_base = A_PO_ADDR_BASE;
         2'd1:    w_po_base = B_PO_ADDR_BASE;
         2'd2:    w_po_base = DA_PO_ADDR_BASE;
         default: w_po_base = DB_PO_ADDR_BASE;
      endcase
   end

   assign w_start  = w_po_base + AW'(cmd_first);
   assign w_span   = CW'(cmd_first) + CW'(cmd_count);
   assign w_reject = !cmd_do &&
                     ((cmd_count == '0) ||
                      (w_span > CW'(PO_ENTRY_COUNT)));

   assign cmd_ready = (r_state == S_IDLE);
   assign w_accept  = cmd_valid && cmd_ready;

   // A single-thread barrel gives every cycle to that thread
   assign w_hit   = (THREAD_COUNT == 1) ||
                    (current_thread == r_thread);
   // Reset cycle never writes, even though state is still LOAD
   assign w_slot  = reset_n && (r_state == S_LOAD) &&
                    w_hit && !slot_cancel;
   assign w_write = w_slot && data_valid;
   assign w_last  = (r_index == (r_count - ONE));
   assign w_addr  = r_base + AW'(r_index);

   assign data_ready  = w_slot;
   assign write_valid = w_write;
   assign write_addr  = w_write ? w_addr  : r_last_addr;
   assign write_data  = w_write ? data_in : r_last_data;
   assign busy        = (r_state == S_LOAD);
   assign done        = (r_state == S_DONE);
   assign error       = r_error;

   // Next-state selection
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (cmd_valid && !w_reject) w_next = S_LOAD;
         S_LOAD:  if (w_write && w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State, command latch, write index and held write outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_thread    <= '0;
         r_base      <= '0;
         r_count     <= '0;
         r_index     <= '0;
         r_error     <= 1'b0;
         r_last_addr <= '0;
         r_last_data <= '0;
      end else begin
         r_state <= w_next;
         r_error <= w_accept && w_reject;
         if (w_accept) begin
            r_thread <= cmd_thread;
            r_base   <= cmd_do ? DO_ADDR : w_start;
            r_count  <= cmd_do ? ONE : cmd_count;
            r_index  <= '0;
         end else if (w_write) begin
            r_index <= r_index + ONE;
         end
         if (w_write) begin
            r_last_addr <= w_addr;
            r_last_data <= data_in;
         end
      end
   end

endmodule
